// File: rtl/stream_mux_arb.sv
// Registered N-to-1 stream selector: fixed-select or round-robin grant feeding a
// one-entry output register with valid/ready handshakes on both sides.
module stream_mux_arb #(
  parameter int NUM_IN = 32,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err_sel
);

  localparam logic             ST_EMPTY = 1'b0;
  localparam logic             ST_FULL  = 1'b1;
  localparam logic [SEL_W-1:0] RR_INIT  = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [DATA_W-1:0] out_data_r;
  logic [SEL_W-1:0]  out_chan_r;
  logic              out_valid_r;
  logic              err_sel_r;
  logic [SEL_W-1:0]  rr_ptr_r;

  logic              can_accept_s;
  logic              sel_ok_s;
  logic              sel_bad_s;
  logic [SEL_W-1:0]  cand_s;
  logic              cand_vld_s;
  logic [SEL_W-1:0]  rr_idx_s;
  logic              rr_hit_s;
  logic [NUM_IN-1:0] in_ready_s;
  logic              xfer_in_s;
  logic [DATA_W-1:0] word_s;

  // Wrap is modulo NUM_IN so non-power-of-two channel counts never search phantom channels.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    return SEL_W'((sum >= NUM_IN) ? (sum - NUM_IN) : sum);
  endfunction

  assign can_accept_s = (out_valid_r == ST_EMPTY) || out_ready;
  assign sel_ok_s     = ({1'b0, sel} < NUM_IN_W);
  assign word_s       = in_data[int'(cand_s)*DATA_W +: DATA_W];

  // Candidate selection: fixed index or first valid channel after the round-robin pointer.
  always_comb begin
    cand_s     = '0;
    cand_vld_s = 1'b0;
    sel_bad_s  = 1'b0;
    rr_idx_s   = '0;
    rr_hit_s   = 1'b0;
    if (mode == 1'b0) begin
      if (sel_ok_s) begin
        cand_s     = sel;
        cand_vld_s = 1'b1;
      end else begin
        sel_bad_s = 1'b1;
      end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        rr_idx_s   = wrap_idx(rr_ptr_r, k);
        rr_hit_s   = !cand_vld_s && in_valid[rr_idx_s];
        cand_s     = rr_hit_s ? rr_idx_s : cand_s;
        cand_vld_s = cand_vld_s || rr_hit_s;
      end
    end
  end

  // Ready goes only to the candidate; in fixed mode it is offered even if that channel is idle.
  always_comb begin
    in_ready_s = '0;
    xfer_in_s  = 1'b0;
    if (cand_vld_s && !reset) begin
      in_ready_s[cand_s] = can_accept_s;
      xfer_in_s          = can_accept_s && in_valid[cand_s];
    end else begin
      in_ready_s = '0;
      xfer_in_s  = 1'b0;
    end
  end

  // Output register, sticky select error and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= ST_EMPTY;
      err_sel_r   <= 1'b0;
      rr_ptr_r    <= RR_INIT;
    end else begin
      if (xfer_in_s) begin
        out_data_r  <= word_s;
        out_chan_r  <= cand_s;
        out_valid_r <= ST_FULL;
      end else if ((out_valid_r == ST_FULL) && out_ready) begin
        out_valid_r <= ST_EMPTY;
      end
      if (sel_bad_s) begin
        err_sel_r <= 1'b1;
      end
      if (xfer_in_s && (mode == 1'b1)) begin
        rr_ptr_r <= cand_s;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;
  assign err_sel   = err_sel_r;

endmodule
